lut_sweep_ctrl: RTL and testbench

// Sequential initiator for a single-port lookup-table memory (ASIZE-bit address,

---
 rtl/lut_sweep_ctrl_if.sv | 33 +++
 rtl/lut_sweep_ctrl.sv | 118 +++++++++++
 tb/tb_lut_sweep_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/lut_sweep_ctrl_if.sv
// Bundle of command, load-stream, dump-stream and LUT-port signals for lut_sweep_ctrl.
// The master modport is the controller's view; the slave modport is its surroundings.
interface lut_sweep_ctrl_if #(
  parameter int ASIZE  = 8,
  parameter int DWIDTH = 8
);
  logic              start;
  logic [1:0]        op;
  logic [DWIDTH-1:0] fill_val;
  logic              busy;
  logic              done;
  logic              s_valid;
  logic [DWIDTH-1:0] s_data;
  logic              s_ready;
  logic              m_valid;
  logic [DWIDTH-1:0] m_data;
  logic [ASIZE-1:0]  m_addr;
  logic              m_ready;
  logic              mem_we;
  logic [ASIZE-1:0]  mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;

  modport master (
    input  start, op, fill_val, s_valid, s_data, m_ready, mem_rdata,
    output busy, done, s_ready, m_valid, m_data, m_addr, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output start, op, fill_val, s_valid, s_data, m_ready, mem_rdata,
    input  busy, done, s_ready, m_valid, m_data, m_addr, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lut_sweep_ctrl.sv
// Sweeps a single-port LUT: fills every entry (constant, ramp or streamed data)
// or dumps every entry out as a valid/ready stream with its address.
module lut_sweep_ctrl #(
  parameter int ASIZE  = 8,
  parameter int DWIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  lut_sweep_ctrl_if.master bus
);
  localparam int               ARANGE = 1 << ASIZE;
  localparam logic [ASIZE-1:0] LAST   = ASIZE'(ARANGE - 1);

  localparam logic [1:0] OP_CONST = 2'b00;
  localparam logic [1:0] OP_RAMP  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_DUMP  = 2'b11;

  typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, OUT, DONE} state_t;

  state_t            state_reg;
  logic [1:0]        op_reg;
  logic [DWIDTH-1:0] val_reg;
  logic [ASIZE-1:0]  cnt_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              m_valid_reg;
  logic [DWIDTH-1:0] m_data_reg;
  logic [ASIZE-1:0]  m_addr_reg;
  logic              wr_fire;
  logic [DWIDTH-1:0] wdata_next;

  // A load beat is written in the same cycle it is accepted, so the write
  // strobe follows s_valid directly while in WRITE.
  assign wr_fire = (state_reg == WRITE) && ((op_reg != OP_LOAD) || bus.s_valid);

  always_comb begin
    wdata_next = '0;
    if (state_reg == WRITE) begin
      case (op_reg)
        OP_CONST: wdata_next = val_reg;
        OP_RAMP:  wdata_next = val_reg + DWIDTH'(cnt_reg);
        default:  wdata_next = bus.s_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      op_reg      <= OP_CONST;
      val_reg     <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_addr_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            op_reg    <= bus.op;
            val_reg   <= bus.fill_val;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= (bus.op == OP_DUMP) ? RD_REQ : WRITE;
          end
        end
        WRITE: begin
          if (wr_fire) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        RD_REQ: state_reg <= RD_WAIT;
        RD_WAIT: begin
          m_data_reg  <= bus.mem_rdata;
          m_addr_reg  <= cnt_reg;
          m_valid_reg <= 1'b1;
          state_reg   <= OUT;
        end
        OUT: begin
          if (bus.m_ready) begin
            m_valid_reg <= 1'b0;
            cnt_reg     <= cnt_reg + 1'b1;
            if (cnt_reg == LAST) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RD_REQ;
            end
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Reset gates the strobe so an aborted command never writes in the reset cycle.
  assign bus.mem_we    = wr_fire && !rst;
  assign bus.mem_addr  = cnt_reg;
  assign bus.mem_wdata = wdata_next;
  assign bus.s_ready   = (state_reg == WRITE) && (op_reg == OP_LOAD);
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.m_valid   = m_valid_reg;
  assign bus.m_data    = m_data_reg;
  assign bus.m_addr    = m_addr_reg;
endmodule

// File: tb/tb_lut_sweep_ctrl.sv
// Self-checking bench for lut_sweep_ctrl (ASIZE=4, DWIDTH=8) with a LUT storage
// model and an expected-contents table derived from the command rules.
module tb_lut_sweep_ctrl;
  localparam int ASIZE  = 4;
  localparam int DWIDTH = 8;
  localparam int ARANGE = 1 << ASIZE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic [DWIDTH-1:0] lut     [ARANGE];
  logic [DWIDTH-1:0] exp_lut [ARANGE];

  lut_sweep_ctrl_if #(.ASIZE(ASIZE), .DWIDTH(DWIDTH)) bus ();

  lut_sweep_ctrl #(.ASIZE(ASIZE), .DWIDTH(DWIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Storage behind the controller: write on the edge, read data one cycle later.
  always @(posedge clk) begin
    if (bus.mem_we) lut[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= lut[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},    32'(bus.busy),      32'd0);
    chk({tag, "_done"},    32'(bus.done),      32'd0);
    chk({tag, "_sready"},  32'(bus.s_ready),   32'd0);
    chk({tag, "_mvalid"},  32'(bus.m_valid),   32'd0);
    chk({tag, "_memwe"},   32'(bus.mem_we),    32'd0);
    chk({tag, "_mdata"},   32'(bus.m_data),    32'd0);
    chk({tag, "_maddr"},   32'(bus.m_addr),    32'd0);
    chk({tag, "_memaddr"}, 32'(bus.mem_addr),  32'd0);
    chk({tag, "_wdata"},   32'(bus.mem_wdata), 32'd0);
  endtask

  // Runs one command to completion; mode 0 uses the fixed 1,0,1,1,0 s_valid pattern.
  task automatic run_cmd(input logic [1:0] cop, input logic [7:0] cval, input int mode);
    int k = 0;
    int beats = 0;
    int cyc = 0;
    logic got_done = 1'b0;
    logic stalled = 1'b0;
    logic prev_hs = 1'b0;
    logic [7:0] held_d = '0;
    logic [3:0] held_a = '0;
    logic [7:0] exp_d;
    logic exp_we;
    int pat [5] = '{1, 0, 1, 1, 0};
    @(negedge clk);
    bus.start = 1'b1; bus.op = cop; bus.fill_val = cval;
    #1;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    while (!got_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      // Extra starts and changing op/fill_val while busy must have no effect.
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.op       = 2'($urandom);
      bus.fill_val = 8'($urandom);
      bus.s_valid  = (mode == 0) ? (pat[(cyc - 1) % 5] == 1) : ($urandom_range(0, 1) == 1);
      bus.s_data   = 8'($urandom);
      bus.m_ready  = ($urandom_range(0, 99) < 30);
      #1;
      chk("busy", 32'(bus.busy), 32'd1);
      chk("s_ready", 32'(bus.s_ready), 32'((cop == 2'b10) && (k < ARANGE)));
      exp_we = (cop != 2'b11) && (k < ARANGE) && ((cop != 2'b10) || bus.s_valid);
      chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
      if (exp_we && bus.mem_we) begin
        case (cop)
          2'b00:   exp_d = cval;
          2'b01:   exp_d = 8'(cval + 8'(k));
          default: exp_d = bus.s_data;
        endcase
        chk("wr_addr", 32'(bus.mem_addr), 32'(k));
        chk("wr_data", 32'(bus.mem_wdata), 32'(exp_d));
        exp_lut[k] = exp_d;
        k++;
      end
      if (cop == 2'b11) begin
        if (bus.m_valid) begin
          chk("beat_gap", 32'(prev_hs), 32'd0);
          chk("m_addr", 32'(bus.m_addr), 32'(beats % ARANGE));
          chk("m_data", 32'(bus.m_data), 32'(exp_lut[beats % ARANGE]));
          if (stalled) begin
            chk("hold_data", 32'(bus.m_data), 32'(held_d));
            chk("hold_addr", 32'(bus.m_addr), 32'(held_a));
          end
          stalled = !bus.m_ready;
          held_d  = bus.m_data;
          held_a  = bus.m_addr;
          prev_hs = bus.m_ready;
          if (bus.m_ready) beats++;
        end else begin
          stalled = 1'b0;
          prev_hs = 1'b0;
        end
      end else begin
        chk("m_valid_off", 32'(bus.m_valid), 32'd0);
      end
      if (bus.done) begin
        got_done = 1'b1;
        chk("done_count", 32'((cop == 2'b11) ? beats : k), 32'(ARANGE));
        if (cop[1] == 1'b0) chk("done_cycle", 32'(cyc), 32'(ARANGE + 1));
      end
    end
    if (!got_done) chk("timeout_done", 32'(got_done), 32'd1);
    @(negedge clk);
    bus.start = 1'b0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    #1;
    chk("after_busy", 32'(bus.busy), 32'd0);
    chk("after_done", 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [7:0] nv;
    for (int i = 0; i < ARANGE; i++) begin
      lut[i] = '0;
      exp_lut[i] = '0;
    end
    bus.start = 1'b0; bus.op = 2'b00; bus.fill_val = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_quiet("reset");
    @(negedge clk);
    rst = 1'b0;

    run_cmd(2'b00, 8'hA5, 0);
    run_cmd(2'b11, 8'h00, 0);
    run_cmd(2'b01, 8'hFE, 0);
    run_cmd(2'b11, 8'h00, 0);
    run_cmd(2'b10, 8'h00, 0);
    run_cmd(2'b11, 8'h00, 0);
    for (int r = 0; r < 4; r++) begin
      run_cmd(2'($urandom_range(0, 2)), 8'($urandom), 1);
      run_cmd(2'b11, 8'($urandom), 1);
    end

    // Abort a constant fill with reset while address 7 is being presented.
    nv = 8'($urandom);
    if (nv == exp_lut[7]) nv = nv + 8'd1;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.fill_val = nv;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.start = (i == 2);
      bus.op    = 2'b11;
      #1;
      chk("abort_we", 32'(bus.mem_we), 32'd1);
      chk("abort_addr", 32'(bus.mem_addr), 32'(i));
      chk("abort_data", 32'(bus.mem_wdata), 32'(nv));
      exp_lut[i] = nv;
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_gate", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_quiet("post_abort");
    run_cmd(2'b11, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
